// File: rtl/lvds_video_rx_decoder_if.sv
// Lane-word input and decoded-video output bundle for lvds_video_rx_decoder.
// master: SERDES front end plus pixel sink side; slave: the decoder.
`timescale 1ns/1ps
interface lvds_video_rx_decoder_if;
    localparam int unsigned WORD_W  = 7;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned TIM_W   = 11;

    logic               word_valid;
    logic [WORD_W-1:0]  ch1_word;
    logic [WORD_W-1:0]  ch2_word;
    logic [WORD_W-1:0]  ch3_word;
    logic [WORD_W-1:0]  clk_word;
    logic               bitslip;
    logic               locked;
    logic               align_retry;
    logic               HSync;
    logic               VSync;
    logic               DataEnable;
    logic [COLOR_W-1:0] Red;
    logic [COLOR_W-1:0] Green;
    logic [COLOR_W-1:0] Blue;
    logic [TIM_W-1:0]   active_width;
    logic [TIM_W-1:0]   active_height;

    modport master (
        output word_valid, ch1_word, ch2_word, ch3_word, clk_word,
        input  bitslip, locked, align_retry, HSync, VSync, DataEnable,
        input  Red, Green, Blue, active_width, active_height
    );

    modport slave (
        input  word_valid, ch1_word, ch2_word, ch3_word, clk_word,
        output bitslip, locked, align_retry, HSync, VSync, DataEnable,
        output Red, Green, Blue, active_width, active_height
    );
endinterface

// File: rtl/lvds_video_rx_decoder.sv
// 7:1 LVDS video receive decoder: word alignment via bitslip, RGB666 + sync unpack.
// Optional active-timing measurement is compiled in with LVDS_RX_TIMING_EN.
`timescale 1ns/1ps
module lvds_video_rx_decoder #(
    parameter logic [6:0]  CLK_PATTERN = 7'b1100011,
    parameter int unsigned SLIP_WAIT   = 4,
    parameter int unsigned LOCK_COUNT  = 16,
    parameter int unsigned ERR_LIMIT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lvds_video_rx_decoder_if.slave  rx
);
    localparam int unsigned SLIP_W  = 3;
    localparam int unsigned WAIT_W  = 4;
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned ERR_W   = $clog2(ERR_LIMIT + 1);
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned TIM_W   = 11;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SLIP_WAIT,
        ST_CHECK,
        ST_LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [SLIP_W-1:0]    slip_q, slip_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [ERR_W-1:0]     err_q, err_d;
    logic                 bitslip_q, bitslip_d;
    logic                 retry_q, retry_d;
    logic                 locked_q, locked_d;
    logic                 hs_q, hs_d;
    logic                 vs_q, vs_d;
    logic                 de_q, de_d;
    logic [COLOR_W-1:0]   red_q, red_d;
    logic [COLOR_W-1:0]   green_q, green_d;
    logic [COLOR_W-1:0]   blue_q, blue_d;
    logic                 clk_match;
    logic                 decode_en;

    assign clk_match = (rx.clk_word == CLK_PATTERN);

    // State and output registers; everything updates only through the *_d terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_HUNT;
            slip_q    <= '0;
            wait_q    <= '0;
            match_q   <= '0;
            err_q     <= '0;
            bitslip_q <= 1'b0;
            retry_q   <= 1'b0;
            locked_q  <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            de_q      <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
        end else begin
            state_q   <= state_d;
            slip_q    <= slip_d;
            wait_q    <= wait_d;
            match_q   <= match_d;
            err_q     <= err_d;
            bitslip_q <= bitslip_d;
            retry_q   <= retry_d;
            locked_q  <= locked_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            de_q      <= de_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    // Alignment FSM and decoded-video next values; idle words freeze everything but pulses.
    always_comb begin
        state_d   = state_q;
        slip_d    = slip_q;
        wait_d    = wait_q;
        match_d   = match_q;
        err_d     = err_q;
        bitslip_d = 1'b0;
        retry_d   = 1'b0;
        locked_d  = locked_q;
        decode_en = 1'b0;
        hs_d      = hs_q;
        vs_d      = vs_q;
        de_d      = de_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;

        if (rx.word_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (clk_match) begin
                        state_d = ST_CHECK;
                        match_d = MATCH_W'(1);
                    end else begin
                        state_d   = ST_SLIP_WAIT;
                        bitslip_d = 1'b1;
                        wait_d    = '0;
                        if (slip_q == SLIP_W'(6)) begin
                            slip_d  = '0;
                            retry_d = 1'b1;
                        end else begin
                            slip_d = slip_q + SLIP_W'(1);
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    // Words right after a slip may straddle the old boundary; drop them.
                    if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_d  = '0;
                        state_d = ST_HUNT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (clk_match) begin
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            match_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        // Slip is deferred to the next HUNT word.
                        state_d = ST_HUNT;
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    decode_en = 1'b1;
                    if (clk_match) begin
                        err_d = '0;
                    end else if (err_q == ERR_W'(ERR_LIMIT - 1)) begin
                        state_d   = ST_HUNT;
                        locked_d  = 1'b0;
                        slip_d    = '0;
                        err_d     = '0;
                        decode_en = 1'b0;
                    end else begin
                        err_d = err_q + ERR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                end
            endcase

            if (decode_en) begin
                red_d   = {rx.ch1_word[5:0], 2'b00};
                green_d = {rx.ch2_word[4:0], rx.ch1_word[6], 2'b00};
                blue_d  = {rx.ch3_word[3:0], rx.ch2_word[6:5], 2'b00};
                hs_d    = rx.ch3_word[4];
                vs_d    = rx.ch3_word[5];
                de_d    = rx.ch3_word[6];
            end else begin
                red_d   = '0;
                green_d = '0;
                blue_d  = '0;
                hs_d    = 1'b1;
                vs_d    = 1'b1;
                de_d    = 1'b0;
            end
        end
    end

    assign rx.bitslip     = bitslip_q;
    assign rx.align_retry = retry_q;
    assign rx.locked      = locked_q;
    assign rx.HSync       = hs_q;
    assign rx.VSync       = vs_q;
    assign rx.DataEnable  = de_q;
    assign rx.Red         = red_q;
    assign rx.Green       = green_q;
    assign rx.Blue        = blue_q;

`ifdef LVDS_RX_TIMING_EN
    logic [TIM_W-1:0] pix_q, pix_d;
    logic [TIM_W-1:0] line_q, line_d;
    logic [TIM_W-1:0] width_q, width_d;
    logic [TIM_W-1:0] height_q, height_d;
    logic [TIM_W-1:0] line_inc;
    logic             de_fall;
    logic             vs_fall;

    function automatic logic [TIM_W-1:0] sat_inc(input logic [TIM_W-1:0] v);
        return (v == {TIM_W{1'b1}}) ? v : v + TIM_W'(1);
    endfunction

    // Timing counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q    <= '0;
            line_q   <= '0;
            width_q  <= '0;
            height_q <= '0;
        end else begin
            pix_q    <= pix_d;
            line_q   <= line_d;
            width_q  <= width_d;
            height_q <= height_d;
        end
    end

    // Edge detection against the previously decoded DE/VSync; cleared whenever not decoding.
    always_comb begin
        pix_d    = pix_q;
        line_d   = line_q;
        width_d  = width_q;
        height_d = height_q;
        line_inc = line_q;
        de_fall  = de_q & ~rx.ch3_word[6];
        vs_fall  = vs_q & ~rx.ch3_word[5];

        if (rx.word_valid) begin
            if (!decode_en) begin
                pix_d    = '0;
                line_d   = '0;
                width_d  = '0;
                height_d = '0;
            end else begin
                if (rx.ch3_word[6]) begin
                    pix_d = sat_inc(pix_q);
                end
                if (de_fall) begin
                    width_d  = pix_q;
                    pix_d    = '0;
                    line_inc = sat_inc(line_q);
                end
                line_d = line_inc;
                if (vs_fall) begin
                    height_d = line_inc;
                    line_d   = '0;
                end
            end
        end
    end

    assign rx.active_width  = width_q;
    assign rx.active_height = height_q;
`else
    assign rx.active_width  = '0;
    assign rx.active_height = '0;
`endif

endmodule
